rsc8_viterbi_decoder: RTL and testbench

//  Hard-decision Viterbi decoder for the 8-state recursive systematic constituent code produced by the

---
 rtl/rsc8_pkg.sv | 15 +
 rtl/rsc8_viterbi_decoder_acs.sv | 22 ++
 rtl/rsc8_viterbi_decoder.sv | 104 ++++++++++
 tb/tb_rsc8_viterbi_decoder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rsc8_pkg.sv
// rsc8_pkg: shared trellis definitions for the 8-state RSC Viterbi decoder
package rsc8_pkg;
  localparam int NSTATES = 8;
  localparam int TAIL = 3;
  typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;
  function automatic logic [1:0] rsc8_out(input logic [2:0] s, input logic a);
    return {a ^ s[1] ^ s[0], a ^ s[2] ^ s[0]};
  endfunction
  function automatic logic [2:0] rsc8_pred(input logic [2:0] n, input logic d);
    return {n[1], n[0], d};
  endfunction
  function automatic logic rsc8_u(input logic [2:0] n, input logic d);
    return n[2] ^ n[0] ^ d;
  endfunction
endpackage

// File: rtl/rsc8_viterbi_decoder_acs.sv
// rsc8_acs_unit: saturating add-compare-select for one next state, tie picks d=0
module rsc8_acs_unit #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  input  logic            i_kill,
  output logic [PM_W-1:0] o_pm,
  output logic            o_d
);
  localparam logic [PM_W-1:0] PM_MAX = '1;
  logic [PM_W:0]   w_s0, w_s1;
  logic [PM_W-1:0] w_c0, w_c1;
  assign w_s0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm0};
  assign w_s1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm1};
  assign w_c0 = w_s0[PM_W] ? PM_MAX : w_s0[PM_W-1:0];
  assign w_c1 = w_s1[PM_W] ? PM_MAX : w_s1[PM_W-1:0];
  assign o_d  = w_c1 < w_c0;
  assign o_pm = i_kill ? PM_MAX : (o_d ? w_c1 : w_c0);
endmodule

// File: rtl/rsc8_viterbi_decoder.sv
// rsc8_viterbi_decoder: hard-decision Viterbi decoder for one terminated RSC block
module rsc8_viterbi_decoder
  import rsc8_pkg::*;
#(
  parameter int K    = 40,
  parameter int PM_W = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sys,
  input  logic            in_par,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            out_last,
  output logic [PM_W-1:0] out_metric,
  output logic            busy
);
  localparam int L  = K + TAIL;
  localparam int SW = $clog2(L);
  localparam logic [SW-1:0] LAST  = SW'(L - 1);
  localparam logic [SW-1:0] KS    = SW'(K);
  localparam logic [SW-1:0] KLAST = SW'(K - 1);
  state_t                r_state, w_next;
  logic [SW-1:0]         r_step;
  logic [PM_W-1:0]       r_pm [NSTATES];
  logic [PM_W-1:0]       w_pm [NSTATES];
  logic [NSTATES-1:0]    w_d;
  logic [NSTATES-1:0]    r_surv [L];
  logic [K-1:0]          r_dec;
  logic [2:0]            r_tn;
  logic [PM_W-1:0]       r_metric;
  logic                  w_acc, w_xfer, w_tail, w_td;
  assign w_acc  = in_valid & in_ready;
  assign w_xfer = out_valid & out_ready;
  assign w_tail = r_step >= KS;
  assign w_td   = r_surv[r_step][r_tn];
  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam logic [2:0] N = 3'(n);
    logic [1:0] w_o0, w_o1;
    assign w_o0 = rsc8_out(rsc8_pred(N, 1'b0), N[2]);
    assign w_o1 = rsc8_out(rsc8_pred(N, 1'b1), N[2]);
    rsc8_acs_unit #(.PM_W(PM_W)) u_acs (
      .i_pm0 (r_pm[rsc8_pred(N, 1'b0)]),
      .i_pm1 (r_pm[rsc8_pred(N, 1'b1)]),
      .i_bm0 (2'(w_o0[1] ^ in_sys) + 2'(w_o0[0] ^ in_par)),
      .i_bm1 (2'(w_o1[1] ^ in_sys) + 2'(w_o1[0] ^ in_par)),
      .i_kill(w_tail & N[2]),
      .o_pm  (w_pm[n]),
      .o_d   (w_d[n])
    );
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACS: if (w_acc) w_next = (r_step == LAST) ? TRACE : ACS;
      TRACE:     if (r_step == '0) w_next = OUT;
      OUT:       if (w_xfer && out_last) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  // r_step counts up through ACS, down through TRACE, then serves as the output index
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_step   <= '0;
      r_tn     <= '0;
      r_metric <= '0;
      for (int i = 0; i < NSTATES; i++) r_pm[i] <= {PM_W{i != 0}};
    end else begin
      case (r_state)
        IDLE, ACS: begin
          r_tn <= '0;
          if (w_acc) begin
            for (int i = 0; i < NSTATES; i++) r_pm[i] <= w_pm[i];
            if (r_step == LAST) r_metric <= w_pm[0];
            else r_step <= r_step + 1'b1;
          end
        end
        TRACE: begin
          r_tn <= rsc8_pred(r_tn, w_td);
          if (r_step != '0) r_step <= r_step - 1'b1;
        end
        default: begin
          for (int i = 0; i < NSTATES; i++) r_pm[i] <= {PM_W{i != 0}};
          if (w_xfer) r_step <= out_last ? '0 : r_step + 1'b1;
        end
      endcase
    end
  always_ff @(posedge clk) begin
    if (w_acc) r_surv[r_step] <= w_d;
    if (r_state == TRACE && r_step < KS) r_dec[r_step] <= rsc8_u(r_tn, w_td);
  end
  assign in_ready   = r_state == IDLE || r_state == ACS;
  assign out_valid  = r_state == OUT;
  assign out_bit    = out_valid & r_dec[r_step];
  assign out_last   = out_valid && r_step == KLAST;
  assign out_metric = r_metric;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_rsc8_viterbi_decoder.sv
// tb_rsc8_viterbi_decoder: directed self-checking bench with a reference RSC encoder
module tb_rsc8_viterbi_decoder;
  localparam int K = 40;
  localparam int PM_W = 8;
  localparam int L = K + 3;
  logic clk = 0, clr = 0, in_valid = 0, in_sys = 0, in_par = 0, out_ready = 0;
  logic in_ready, out_valid, out_bit, out_last, busy;
  logic [PM_W-1:0] out_metric;
  int total = 0, bad = 0;
  logic [K-1:0] u, got;
  logic [L-1:0] ts, tp;
  logic [63:0] rv;
  int last_at, lat;
  always #5 clk = ~clk;
  rsc8_viterbi_decoder #(.K(K), .PM_W(PM_W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_sys(in_sys), .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .out_metric(out_metric), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic encode();
    logic [2:0] s;
    logic a;
    s = '0;
    for (int i = 0; i < K; i++) begin
      a = u[i] ^ s[1] ^ s[0];
      ts[i] = u[i];
      tp[i] = a ^ s[2] ^ s[0];
      s = {a, s[2], s[1]};
    end
    for (int i = K; i < L; i++) begin
      ts[i] = s[1] ^ s[0];
      tp[i] = s[2] ^ s[0];
      s = {1'b0, s[2], s[1]};
    end
  endtask
  task automatic send(input int n, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 0;
      end
      @(negedge clk);
      in_valid = 1;
      in_sys = ts[i];
      in_par = tp[i];
      w = 0;
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) chk("in_ready_wait", in_ready, 1);
      @(posedge clk);
    end
  endtask
  task automatic recv(input logic [PM_W-1:0] em, input int stall_at, input bit rnd, input bit chk_lat);
    logic b, l;
    got = '0;
    last_at = -1;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    chk("trace_in_ready", in_ready, 0);
    chk("trace_busy", busy, 1);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_first", out_valid, 1);
    if (chk_lat) chk("latency", lat, L + 1);
    chk("metric", out_metric, em);
    for (int idx = 0; idx < K; idx++) begin
      if (idx == stall_at) begin
        b = out_bit;
        l = out_last;
        out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_bit", out_bit, b);
          chk("stall_last", out_last, l);
          chk("stall_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
        end
      end
      while (rnd && $urandom_range(0, 2) == 0) begin
        out_ready = 0;
        @(negedge clk);
      end
      chk("out_valid", out_valid, 1);
      got[idx] = out_bit;
      if (out_last) last_at = idx;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 0;
    chk("decoded", got, u);
    chk("last_pos", last_at, K - 1);
    chk("drained_valid", out_valid, 0);
    chk("drained_in_ready", in_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_metric", out_metric, 0);
    chk("rst_busy", busy, 0);
    clr = 1;
    u = '0;
    encode();
    send(L, 0);
    recv(0, -1, 0, 1);
    u = '0;
    u[0] = 1'b1;
    encode();
    send(L, 0);
    recv(0, -1, 0, 1);
    repeat (100) begin
      rv = {$urandom(), $urandom()};
      u = rv[K-1:0];
      encode();
      send(L, 1);
      recv(0, -1, 1, 0);
    end
    encode();
    tp[7] = ~tp[7];
    send(L, 0);
    recv(1, -1, 0, 1);
    encode();
    tp[7] = ~tp[7];
    ts[20] = ~ts[20];
    send(L, 0);
    recv(2, -1, 0, 1);
    rv = {$urandom(), $urandom()};
    u = rv[K-1:0];
    encode();
    send(L, 0);
    recv(0, 20, 0, 1);
    rv = {$urandom(), $urandom()};
    u = rv[K-1:0];
    encode();
    send(20, 0);
    @(negedge clk);
    chk("acs_busy", busy, 1);
    clr = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_metric", out_metric, 0);
    in_valid = 0;
    @(negedge clk);
    clr = 1;
    rv = {$urandom(), $urandom()};
    u = ~rv[K-1:0];
    encode();
    send(L, 0);
    recv(0, -1, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
